acc_drain_requant: RTL and testbench

Output-side drain for the 32x32 MAC array. On completion of a Cout tile it captures the 32 signed 32-bit accumulators and 32 per-channel biases, then streams one requantized INT8 activation per cycle over a valid/ready interface to the output buffer. Per channel it computes bias add, optional leaky ReLU, fixed-point scale, round and saturate. It sits between the MAC array accumulator outputs and the activation write-back path.

---
 rtl/dpu_pkg.sv | 42 ++++
 rtl/requant_lane.sv | 47 ++++
 rtl/acc_drain_requant.sv | 170 +++++++++++++++++
 tb/tb_acc_drain_requant.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dpu_pkg.sv
// Shared widths, constants and types for the output-side drain datapath.
package dpu_pkg;

    localparam int N_CH        = 32;
    localparam int ACC_W       = 32;
    localparam int MULT_W      = 16;
    localparam int CH_W        = 5;
    localparam int SHIFT_IN_W  = 6;
    localparam int SHIFT_W     = 5;
    localparam int SUM_W       = ACC_W + 1;
    localparam int LEAKY_W     = 38;
    localparam int PROD_W      = 55;

    localparam int LEAKY_NUM   = 13;
    localparam int LEAKY_SHIFT = 7;

    typedef logic signed [ACC_W-1:0]   acc_t;
    typedef logic signed [7:0]         act_t;
    typedef logic signed [LEAKY_W-1:0] leaky_t;

    localparam act_t ACT_MAX = 8'sd127;
    localparam act_t ACT_MIN = -8'sd128;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } drain_state_e;

    // Clamp a scaled product into the INT8 activation range.
    function automatic act_t sat_act(input logic signed [PROD_W-1:0] v);
        act_t res;
        if (v > PROD_W'(ACT_MAX)) begin
            res = ACT_MAX;
        end else if (v < PROD_W'(ACT_MIN)) begin
            res = ACT_MIN;
        end else begin
            res = v[7:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/requant_lane.sv
// One requantization lane, purely combinational. The front half (bias add and
// leaky ReLU) and back half (scale, round, saturate) are exposed separately so
// the owner can register the leaky result between them.
module requant_lane
    import dpu_pkg::*;
(
    input  logic signed [ACC_W-1:0]   i_acc,
    input  logic signed [ACC_W-1:0]   i_bias,
    input  logic                      i_leaky_en,
    output logic signed [LEAKY_W-1:0] o_l,
    input  logic signed [LEAKY_W-1:0] i_l,
    input  logic [MULT_W-1:0]         i_mult,
    input  logic [SHIFT_W-1:0]        i_shift,
    output logic signed [7:0]         o_data
);

    logic signed [SUM_W-1:0]   w_sum;
    logic signed [LEAKY_W-1:0] w_sum_ext;
    logic signed [LEAKY_W-1:0] w_leaky;
    logic signed [PROD_W-1:0]  w_mult_ext;
    logic signed [PROD_W-1:0]  w_prod;
    logic signed [PROD_W-1:0]  w_rnd;
    logic signed [PROD_W-1:0]  w_shifted;

    // Two 32-bit signed values cannot overflow a 33-bit sum.
    assign w_sum     = SUM_W'(i_acc) + SUM_W'(i_bias);
    assign w_sum_ext = LEAKY_W'(w_sum);
    // Slope of 13/128 (~0.1); arithmetic shift floors toward -inf.
    assign w_leaky   = (w_sum_ext * LEAKY_W'(LEAKY_NUM)) >>> LEAKY_SHIFT;
    assign o_l       = (i_leaky_en && w_sum[SUM_W-1]) ? w_leaky : w_sum_ext;

    // Multiplier is unsigned, so it is zero-extended into the signed product.
    assign w_mult_ext = {{(PROD_W-MULT_W){1'b0}}, i_mult};
    assign w_prod     = PROD_W'(i_l) * w_mult_ext;

    // Half-LSB rounding constant; adding it before the floor shift rounds half toward +inf.
    always_comb begin
        w_rnd = '0;
        if (i_shift != '0) begin
            w_rnd = PROD_W'(1) << (i_shift - SHIFT_W'(1));
        end
    end

    assign w_shifted = (w_prod + w_rnd) >>> i_shift;
    assign o_data    = sat_act(w_shifted);

endmodule

// File: rtl/acc_drain_requant.sv
// Drains one Cout tile of MAC accumulators: captures accumulators, biases and
// requant config, then streams one INT8 activation per cycle over valid/ready.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// ST_IDLE | tile_ready high, waiting for a tile; captured registers hold
// ST_RUN  | issuing channels into the two-stage pipeline until out_last drains
module acc_drain_requant
    import dpu_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_tile_valid,
    output logic                     o_tile_ready,
    input  logic signed [ACC_W-1:0]  i_acc_in  [0:N_CH-1],
    input  logic signed [ACC_W-1:0]  i_bias_in [0:N_CH-1],
    input  logic [MULT_W-1:0]        i_mult,
    input  logic [SHIFT_IN_W-1:0]    i_shift,
    input  logic                     i_leaky_en,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic signed [7:0]        o_out_data,
    output logic [CH_W-1:0]          o_out_ch,
    output logic                     o_out_last,
    output logic                     o_busy
);

    drain_state_e              r_state;
    logic                      r_tile_ready;
    logic [CH_W-1:0]           r_cnt;
    logic                      r_issue_done;

    logic signed [ACC_W-1:0]   r_acc  [0:N_CH-1];
    logic signed [ACC_W-1:0]   r_bias [0:N_CH-1];
    logic [MULT_W-1:0]         r_mult;
    logic [SHIFT_W-1:0]        r_shift;
    logic                      r_leaky;

    logic                      r_s1_valid;
    logic signed [LEAKY_W-1:0] r_s1_l;
    logic [CH_W-1:0]           r_s1_ch;

    logic                      r_out_valid;
    logic signed [7:0]         r_out_data;
    logic [CH_W-1:0]           r_out_ch;
    logic                      r_out_last;

    logic                      w_accept;
    logic                      w_adv;
    logic                      w_issue;
    logic                      w_last_hs;
    logic signed [LEAKY_W-1:0] w_l;
    logic signed [7:0]         w_data;

    assign w_accept  = i_tile_valid && r_tile_ready;
    // The whole pipeline moves together; a stalled output beat freezes everything.
    assign w_adv     = !r_out_valid || i_out_ready;
    assign w_issue   = (r_state == ST_RUN) && !r_issue_done && w_adv;
    assign w_last_hs = r_out_valid && i_out_ready && r_out_last;

    requant_lane u_lane (
        .i_acc      (r_acc[r_cnt]),
        .i_bias     (r_bias[r_cnt]),
        .i_leaky_en (r_leaky),
        .o_l        (w_l),
        .i_l        (r_s1_l),
        .i_mult     (r_mult),
        .i_shift    (r_shift),
        .o_data     (w_data)
    );

    // Capture the tile and its config on the accept edge only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                r_acc[i]  <= '0;
                r_bias[i] <= '0;
            end
            r_mult  <= '0;
            r_shift <= '0;
            r_leaky <= 1'b0;
        end else if (w_accept) begin
            for (int i = 0; i < N_CH; i++) begin
                r_acc[i]  <= i_acc_in[i];
                r_bias[i] <= i_bias_in[i];
            end
            r_mult  <= i_mult;
            r_shift <= (i_shift > SHIFT_IN_W'(31)) ? SHIFT_W'(31) : i_shift[SHIFT_W-1:0];
            r_leaky <= i_leaky_en;
        end
    end

    // Sequencing FSM with the channel issue counter and registered tile_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_tile_ready <= 1'b1;
            r_cnt        <= '0;
            r_issue_done <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state      <= ST_RUN;
                        r_tile_ready <= 1'b0;
                        r_cnt        <= '0;
                        r_issue_done <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (w_issue) begin
                        if (r_cnt == CH_W'(N_CH-1)) begin
                            r_issue_done <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CH_W'(1);
                        end
                    end
                    if (w_last_hs) begin
                        r_state      <= ST_IDLE;
                        r_tile_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_tile_ready <= 1'b1;
                end
            endcase
        end
    end

    // Stage 1: register the post-leaky value and its channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_l     <= '0;
            r_s1_ch    <= '0;
        end else if (w_adv) begin
            r_s1_valid <= w_issue;
            if (w_issue) begin
                r_s1_l  <= w_l;
                r_s1_ch <= r_cnt;
            end
        end
    end

    // Stage 2: register the requantized output beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_out_last  <= 1'b0;
        end else if (w_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_data <= w_data;
                r_out_ch   <= r_s1_ch;
                r_out_last <= (r_s1_ch == CH_W'(N_CH-1));
            end
        end
    end

    assign o_tile_ready = r_tile_ready;
    assign o_out_valid  = r_out_valid;
    assign o_out_data   = r_out_data;
    assign o_out_ch     = r_out_ch;
    assign o_out_last   = r_out_last;
    assign o_busy       = (r_state == ST_RUN) || r_s1_valid || r_out_valid;

endmodule

// File: tb/tb_acc_drain_requant.sv
// Scoreboard bench for acc_drain_requant: directed tiles push expected beats,
// a negedge monitor pops and compares each handshaked beat.
module tb_acc_drain_requant;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               i_tile_valid;
    logic               o_tile_ready;
    logic signed [31:0] i_acc_in  [0:31];
    logic signed [31:0] i_bias_in [0:31];
    logic [15:0]        i_mult;
    logic [5:0]         i_shift;
    logic               i_leaky_en;
    logic               o_out_valid;
    logic               i_out_ready;
    logic signed [7:0]  o_out_data;
    logic [4:0]         o_out_ch;
    logic               o_out_last;
    logic               o_busy;

    int          checks   = 0;
    int          failures = 0;
    int          beats    = 0;
    int          exp_d [0:31];
    logic [13:0] exp_q [$];
    logic [13:0] mon_e;
    logic [13:0] held;
    bit          stalled  = 1'b0;

    always #5 clk = ~clk;

    acc_drain_requant dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_tile_valid (i_tile_valid),
        .o_tile_ready (o_tile_ready),
        .i_acc_in     (i_acc_in),
        .i_bias_in    (i_bias_in),
        .i_mult       (i_mult),
        .i_shift      (i_shift),
        .i_leaky_en   (i_leaky_en),
        .o_out_valid  (o_out_valid),
        .i_out_ready  (i_out_ready),
        .o_out_data   (o_out_data),
        .o_out_ch     (o_out_ch),
        .o_out_last   (o_out_last),
        .o_busy       (o_busy)
    );

    task automatic check(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: compare every handshaked beat against the scoreboard, and
    // verify a stalled beat is held unchanged.
    always @(negedge clk) begin
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (stalled && o_out_valid) begin
                check({o_out_last, o_out_ch, o_out_data} == held, "stall_hold",
                      int'({o_out_last, o_out_ch, o_out_data}), int'(held));
            end
            if (o_out_valid && i_out_ready) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_beat", int'(o_out_ch), -1);
                end else begin
                    mon_e = exp_q.pop_front();
                    check({o_out_last, o_out_ch, o_out_data} == mon_e,
                          $sformatf("beat ch%0d(got ch%0d last%0d)", mon_e[12:8], o_out_ch, o_out_last),
                          int'(o_out_data), int'($signed(mon_e[7:0])));
                    beats++;
                end
            end
            stalled = o_out_valid && !i_out_ready;
            held    = {o_out_last, o_out_ch, o_out_data};
        end
    end

    task automatic clear_vecs();
        for (int k = 0; k < 32; k++) begin
            i_acc_in[k]  = '0;
            i_bias_in[k] = '0;
            exp_d[k]     = 0;
        end
    endtask

    task automatic set_cfg(input int mult, input int shift, input bit leaky);
        i_mult     = 16'(mult);
        i_shift    = 6'(shift);
        i_leaky_en = leaky;
    endtask

    task automatic push_exp();
        for (int k = 0; k < 32; k++) begin
            exp_q.push_back({(k == 31), 5'(k), 8'(exp_d[k])});
        end
    endtask

    // mode 0: out_ready always high; mode 1: toggling, a 5-cycle hold-off and
    // a tile_valid pulse during RUN.
    task automatic run_tile(input int mode, input bit lat);
        int cyc;
        push_exp();
        i_tile_valid = 1'b1;
        @(posedge clk); #1;
        i_tile_valid = 1'b0;
        cyc = 0;
        while (!(exp_q.size() == 0 && o_tile_ready) && cyc < 400) begin
            if (mode == 1) begin
                i_out_ready = (cyc >= 12 && cyc < 17) ? 1'b0 : (cyc % 2 == 0);
                if (cyc == 6) begin
                    for (int k = 0; k < 32; k++) i_bias_in[k] = 32'sd100;
                    i_tile_valid = 1'b1;
                end else begin
                    i_tile_valid = 1'b0;
                end
            end else begin
                i_out_ready = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
            if (lat) begin
                if (cyc == 1) check(!o_out_valid, "lat_e1_valid_low", int'(o_out_valid), 0);
                if (cyc == 2) check(o_out_valid && o_out_ch == 5'd0, "lat_e2_ch0", int'(o_out_valid), 1);
                if (cyc == 2) check(o_busy && !o_tile_ready, "busy_run", int'(o_busy), 1);
                if (cyc == 33) check(o_out_last && !o_tile_ready, "lat_e33_last", int'(o_out_last), 1);
                if (cyc == 34) check(o_tile_ready && !o_out_valid, "lat_e34_ready", int'(o_tile_ready), 1);
            end
        end
        i_tile_valid = 1'b0;
        i_out_ready  = 1'b1;
        check(cyc < 400, "tile_timeout", cyc, 400);
        if (exp_q.size() != 0) exp_q.delete();
    endtask

    initial begin
        int cyc;
        rst_n        = 1'b0;
        i_tile_valid = 1'b0;
        i_out_ready  = 1'b1;
        set_cfg(1, 0, 1'b0);
        clear_vecs();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check(o_tile_ready && !o_out_valid && !o_busy, "reset_ctrl", int'({o_tile_ready, o_out_valid, o_busy}), 4);
        check(o_out_data == 8'sd0 && o_out_ch == 5'd0 && !o_out_last, "reset_data",
              int'({o_out_last, o_out_ch, o_out_data}), 0);

        // Channel order and latency: bias[k]=k.
        clear_vecs();
        for (int k = 0; k < 32; k++) begin i_bias_in[k] = k; exp_d[k] = k; end
        set_cfg(1, 0, 1'b0);
        run_tile(0, 1'b1);

        // Saturation.
        clear_vecs();
        i_acc_in[0] = 32'sd1000;  exp_d[0] = 127;
        i_acc_in[1] = -32'sd1000; exp_d[1] = -128;
        i_acc_in[2] = 32'sd127;   exp_d[2] = 127;
        i_acc_in[3] = -32'sd128;  exp_d[3] = -128;
        i_acc_in[4] = 32'sd128;   exp_d[4] = 127;
        i_acc_in[5] = -32'sd129;  exp_d[5] = -128;
        set_cfg(1, 0, 1'b0);
        run_tile(0, 1'b0);

        // Rounding, shift=1.
        clear_vecs();
        i_acc_in[0] = 32'sd3;  exp_d[0] = 2;
        i_acc_in[1] = -32'sd3; exp_d[1] = -1;
        set_cfg(1, 1, 1'b0);
        run_tile(0, 1'b0);

        // Rounding, shift=2.
        clear_vecs();
        i_acc_in[0] = 32'sd5; exp_d[0] = 1;
        i_acc_in[1] = 32'sd6; exp_d[1] = 2;
        set_cfg(1, 2, 1'b0);
        run_tile(0, 1'b0);

        // shift=40 clamps to 31.
        clear_vecs();
        i_acc_in[0] = 32'sh4000_0000; exp_d[0] = 1;
        i_acc_in[1] = 32'sh3FFF_FFFF; exp_d[1] = 0;
        set_cfg(1, 40, 1'b0);
        run_tile(0, 1'b0);

        // Leaky ReLU.
        clear_vecs();
        i_acc_in[0] = -32'sd100; exp_d[0] = -11;
        i_acc_in[1] = 32'sd50;   exp_d[1] = 50;
        i_acc_in[2] = -32'sd1;   exp_d[2] = -1;
        i_acc_in[3] = -32'sd60;  i_bias_in[3] = 32'sd10; exp_d[3] = -6;
        set_cfg(1, 0, 1'b1);
        run_tile(0, 1'b0);

        // Scale with leaky off.
        clear_vecs();
        i_acc_in[0] = -32'sd100; exp_d[0] = -100;
        i_acc_in[1] = 32'sd1;    exp_d[1] = 1;
        i_acc_in[2] = 32'sd200;  exp_d[2] = 127;
        set_cfg(256, 8, 1'b0);
        run_tile(0, 1'b0);

        // Backpressure and ignored tile_valid during RUN.
        clear_vecs();
        for (int k = 0; k < 32; k++) begin i_bias_in[k] = k; exp_d[k] = k; end
        set_cfg(1, 0, 1'b0);
        beats = 0;
        run_tile(1, 1'b0);
        check(beats == 32, "bp_beat_count", beats, 32);

        // Reset mid-tile after the ch10 handshake.
        clear_vecs();
        for (int k = 0; k < 32; k++) begin i_bias_in[k] = k; exp_d[k] = k; end
        set_cfg(1, 0, 1'b0);
        beats = 0;
        push_exp();
        i_tile_valid = 1'b1;
        @(posedge clk); #1;
        i_tile_valid = 1'b0;
        cyc = 0;
        while (beats < 11 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check(cyc < 100, "rst_wait_timeout", cyc, 100);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check(!o_out_valid && o_tile_ready && !o_busy, "rst_during", int'({o_out_valid, o_tile_ready, o_busy}), 2);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check(!o_out_valid && o_tile_ready, "rst_after", int'({o_out_valid, o_tile_ready}), 1);

        clear_vecs();
        for (int k = 0; k < 32; k++) begin i_bias_in[k] = k + 1; exp_d[k] = k + 1; end
        beats = 0;
        run_tile(0, 1'b0);
        check(beats == 32, "post_rst_beat_count", beats, 32);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
